mmio_interconnect: RTL and testbench

// Parametrised memory-mapped interconnect between the core data port and NUM_SLAVES peripherals (DMEM, UART, GPIO, ...).

---
 rtl/mmio_interconnect.sv | 205 ++++++++++++++++++++
 tb/tb_mmio_interconnect.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mmio_interconnect.sv
// Memory-mapped interconnect between the core data port and NUM_SLAVES peripherals.
// The address is decoded against a table of regions; the lowest index wins on overlap.
// Writes are broadcast and strobed to the hit slave in the same cycle.
// One read may be outstanding at a time, and each read is bounded by a timeout.
// A read to an unmapped address, or one that times out, returns ERR_DATA.
// The first fault (unmapped access or read timeout) is held in sticky registers until cleared.
module mmio_interconnect #(
    parameter int                         NUM_SLAVES     = 4,
    parameter logic [NUM_SLAVES*32-1:0]   SLAVE_BASE     = {NUM_SLAVES{32'h0}},
    parameter logic [NUM_SLAVES*32-1:0]   SLAVE_SIZE     = {NUM_SLAVES{32'h0}},
    parameter int                         TIMEOUT_CYCLES = 16,
    parameter logic [31:0]                ERR_DATA       = 32'hDEADBEEF
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [31:0]                address,
    input  logic [31:0]                write_data,
    input  logic [3:0]                 write_mask,
    input  logic                       write_enable,
    input  logic                       read_enable,
    output logic [31:0]                read_data,
    output logic                       read_valid,
    output logic                       busy,
    output logic [31:0]                s_address,
    output logic [31:0]                s_write_data,
    output logic [3:0]                 s_write_mask,
    output logic [NUM_SLAVES-1:0]      s_write_enable,
    output logic [NUM_SLAVES-1:0]      s_read_enable,
    input  logic [NUM_SLAVES*32-1:0]   s_read_data,
    input  logic [NUM_SLAVES-1:0]      s_read_valid,
    output logic                       fault_valid,
    output logic [31:0]                fault_addr,
    output logic                       fault_is_write,
    output logic                       fault_cause,
    input  logic                       fault_clear
);

    localparam int IDX_W = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;
    localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t            state_q;
    logic [IDX_W-1:0]  idx_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [31:0]       rd_addr_q;
    logic [31:0]       read_data_q;
    logic              read_valid_q;
    logic              fault_valid_q;
    logic [31:0]       fault_addr_q;
    logic              fault_is_write_q;
    logic              fault_cause_q;

    logic [NUM_SLAVES-1:0] hit_raw;
    logic [NUM_SLAVES-1:0] hit_onehot;
    logic                  hit_any;
    logic [IDX_W-1:0]      hit_idx;

    logic                  sel_valid;
    logic [31:0]           sel_data;
    logic                  timeout_hit;

    logic                  fault_ev_d;
    logic [31:0]           fault_addr_d;
    logic                  fault_is_write_d;
    logic                  fault_cause_d;

    // Region compare per slave, done in 33 bits so that BASE+SIZE cannot wrap.
    generate
        for (genvar gi = 0; gi < NUM_SLAVES; gi++) begin : g_dec
            localparam logic [32:0] BASE = {1'b0, SLAVE_BASE[gi*32 +: 32]};
            localparam logic [32:0] SIZE = {1'b0, SLAVE_SIZE[gi*32 +: 32]};
            assign hit_raw[gi] = (SIZE != 33'd0)
                              && ({1'b0, address} >= BASE)
                              && ({1'b0, address} <  BASE + SIZE);
        end
    endgenerate

    // Priority pick: isolate the lowest set hit bit, and encode its index.
    always_comb begin
        hit_onehot = hit_raw & (~hit_raw + NUM_SLAVES'(1));
        hit_any    = |hit_raw;
        hit_idx    = '0;
        for (int i = NUM_SLAVES - 1; i >= 0; i--) begin
            if (hit_raw[i]) begin
                hit_idx = IDX_W'(i);
            end
        end
    end

    // Select the response lane of the slave that owns the outstanding read.
    always_comb begin
        sel_valid = 1'b0;
        sel_data  = '0;
        for (int i = 0; i < NUM_SLAVES; i++) begin
            if (idx_q == IDX_W'(i)) begin
                sel_valid = s_read_valid[i];
                sel_data  = s_read_data[i*32 +: 32];
            end
        end
    end

    assign timeout_hit = (state_q == ST_WAIT) && !sel_valid && (cnt_q == CNT_LAST);

    // Fault source for this cycle. A timeout reports the latched read address, not the live bus.
    always_comb begin
        fault_ev_d       = 1'b0;
        fault_addr_d     = address;
        fault_is_write_d = 1'b0;
        fault_cause_d    = 1'b0;
        if (timeout_hit) begin
            fault_ev_d    = 1'b1;
            fault_addr_d  = rd_addr_q;
            fault_cause_d = 1'b1;
        end else if ((state_q == ST_IDLE) && read_enable && !hit_any) begin
            fault_ev_d = 1'b1;
        end else if (write_enable && !hit_any) begin
            fault_ev_d       = 1'b1;
            fault_is_write_d = 1'b1;
        end
    end

    assign s_address      = address;
    assign s_write_data   = write_data;
    assign s_write_mask   = write_mask;
    assign s_write_enable = (rst && write_enable) ? hit_onehot : '0;
    assign s_read_enable  = (rst && read_enable && (state_q == ST_IDLE)) ? hit_onehot : '0;

    assign busy           = (state_q == ST_WAIT);
    assign read_data      = read_data_q;
    assign read_valid     = read_valid_q;
    assign fault_valid    = fault_valid_q;
    assign fault_addr     = fault_addr_q;
    assign fault_is_write = fault_is_write_q;
    assign fault_cause    = fault_cause_q;

    // Read-tracking FSM with registered response, plus sticky first-fault capture.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q          <= ST_IDLE;
            idx_q            <= '0;
            cnt_q            <= '0;
            rd_addr_q        <= '0;
            read_data_q      <= '0;
            read_valid_q     <= 1'b0;
            fault_valid_q    <= 1'b0;
            fault_addr_q     <= '0;
            fault_is_write_q <= 1'b0;
            fault_cause_q    <= 1'b0;
        end else begin
            read_valid_q <= 1'b0;

            if (fault_ev_d && (!fault_valid_q || fault_clear)) begin
                fault_valid_q    <= 1'b1;
                fault_addr_q     <= fault_addr_d;
                fault_is_write_q <= fault_is_write_d;
                fault_cause_q    <= fault_cause_d;
            end else if (fault_clear) begin
                fault_valid_q <= 1'b0;
            end

            case (state_q)
                ST_IDLE: begin
                    if (read_enable) begin
                        if (hit_any) begin
                            idx_q     <= hit_idx;
                            cnt_q     <= '0;
                            rd_addr_q <= address;
                            state_q   <= ST_WAIT;
                        end else begin
                            state_q <= ST_RESP;
                        end
                    end
                end
                ST_WAIT: begin
                    if (sel_valid) begin
                        read_data_q  <= sel_data;
                        read_valid_q <= 1'b1;
                        state_q      <= ST_IDLE;
                    end else if (cnt_q == CNT_LAST) begin
                        read_data_q  <= ERR_DATA;
                        read_valid_q <= 1'b1;
                        state_q      <= ST_IDLE;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                ST_RESP: begin
                    read_data_q  <= ERR_DATA;
                    read_valid_q <= 1'b1;
                    state_q      <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mmio_interconnect.sv
// Bench for mmio_interconnect. It keeps a transaction-level model: each accepted read
// is predicted to complete at a fixed cycle, computed from the slave latency, the timeout,
// or the unmapped path. A negedge process compares every output against the model on
// every cycle. Directed steps pin a few literal values, and a random phase follows.
module tb_mmio_interconnect;
    localparam int          NS  = 4;
    localparam int          T   = 16;
    localparam logic [31:0] ERR = 32'hDEADBEEF;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                 rst;
    logic [31:0]          address, write_data;
    logic [3:0]           write_mask;
    logic                 write_enable, read_enable;
    logic [31:0]          read_data;
    logic                 read_valid, busy;
    logic [31:0]          s_address, s_write_data;
    logic [3:0]           s_write_mask;
    logic [NS-1:0]        s_write_enable, s_read_enable, s_read_valid;
    logic [NS*32-1:0]     s_read_data;
    logic                 fault_valid;
    logic [31:0]          fault_addr;
    logic                 fault_is_write, fault_cause, fault_clear;

    mmio_interconnect #(
        .NUM_SLAVES     (NS),
        .SLAVE_BASE     ({32'h80000000, 32'hA0000000, 32'h10010000, 32'h90000000}),
        .SLAVE_SIZE     ({32'h00000800, 32'h00000004, 32'h00000200, 32'h00000800}),
        .TIMEOUT_CYCLES (T),
        .ERR_DATA       (ERR)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .address        (address),
        .write_data     (write_data),
        .write_mask     (write_mask),
        .write_enable   (write_enable),
        .read_enable    (read_enable),
        .read_data      (read_data),
        .read_valid     (read_valid),
        .busy           (busy),
        .s_address      (s_address),
        .s_write_data   (s_write_data),
        .s_write_mask   (s_write_mask),
        .s_write_enable (s_write_enable),
        .s_read_enable  (s_read_enable),
        .s_read_data    (s_read_data),
        .s_read_valid   (s_read_valid),
        .fault_valid    (fault_valid),
        .fault_addr     (fault_addr),
        .fault_is_write (fault_is_write),
        .fault_cause    (fault_cause),
        .fault_clear    (fault_clear)
    );

    logic [31:0] bs_a [NS] = '{32'h90000000, 32'h10010000, 32'hA0000000, 32'h80000000};
    logic [31:0] sz_a [NS] = '{32'h00000800, 32'h00000200, 32'h00000004, 32'h00000800};

    int  total = 0;
    int  bad   = 0;
    int  cyc   = 0;
    bit  chk_en = 1'b0;

    // model: outstanding read as a scheduled completion
    bit          has_read = 1'b0;
    int          rd_acc, rd_resp, rd_idx, rd_lat;
    bit          rd_to;
    logic [31:0] rd_addr, rd_data;
    // model: visible registers
    logic [31:0] m_rd;
    logic        m_fv, m_fw, m_fc;
    logic [31:0] m_fa;
    // expected values for the current cycle
    logic        e_rv, e_busy;
    logic [NS-1:0] e_sre, e_swe;
    // inputs of the previous cycle
    logic        p_rst = 1'b0, p_we = 1'b0, p_fclr = 1'b0;
    logic [31:0] p_addr = '0;
    bit          p_acc = 1'b0;
    int          p_idx = -1;
    logic [NS-1:0] extra_sv = '0;

    function automatic int dec(input logic [31:0] a);
        logic [63:0] aa, lo, hi;
        aa = {32'h0, a};
        for (int i = 0; i < NS; i++) begin
            lo = {32'h0, bs_a[i]};
            hi = lo + {32'h0, sz_a[i]};
            if (sz_a[i] != 32'h0 && aa >= lo && aa < hi) return i;
        end
        return -1;
    endfunction

    function automatic logic [NS-1:0] oh(input int i);
        logic [NS-1:0] r;
        r = '0;
        if (i >= 0) r[i] = 1'b1;
        return r;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s cyc=%0d got=%h want=%h", nm, cyc, act, exp);
        end
    endtask

    // Advance one cycle: apply the model effects of the previous cycle's edge, then drive new inputs.
    task automatic drive_cycle(input logic rn, input logic [31:0] a, input logic [3:0] wm,
                               input logic we_in, input logic re, input logic fclr,
                               input int lat, input logic [31:0] rdat);
        int            idx;
        logic          we;
        bit            acc, to_dec, ev;
        logic [31:0]   ev_addr;
        logic          ev_w, ev_c;
        logic [NS-1:0] sv;
        logic [NS*32-1:0] sd;
        @(posedge clk);
        #1;
        cyc++;
        if (!p_rst) begin
            has_read = 1'b0;
            m_rd = '0; m_fv = 1'b0; m_fa = '0; m_fw = 1'b0; m_fc = 1'b0;
            chk_en = 1'b1;
        end else begin
            ev = 1'b0; ev_addr = p_addr; ev_w = 1'b0; ev_c = 1'b0;
            if (has_read && rd_idx >= 0 && rd_to && cyc == rd_resp) begin
                ev = 1'b1; ev_addr = rd_addr; ev_c = 1'b1;
            end else if (p_acc && p_idx < 0) begin
                ev = 1'b1;
            end else if (p_we && dec(p_addr) < 0) begin
                ev = 1'b1; ev_w = 1'b1;
            end
            if (ev && (!m_fv || p_fclr)) begin
                m_fv = 1'b1; m_fa = ev_addr; m_fw = ev_w; m_fc = ev_c;
            end else if (p_fclr) begin
                m_fv = 1'b0;
            end
        end
        e_rv = has_read && (cyc == rd_resp);
        if (e_rv) m_rd = rd_data;

        idx    = dec(a);
        we     = we_in;
        acc    = rn && re && !(has_read && cyc < rd_resp);
        to_dec = has_read && rd_idx >= 0 && rd_to && (cyc == rd_resp - 1);
        // keep at most one fault source per cycle
        if (we && idx < 0 && (acc || to_dec)) we = 1'b0;
        if (acc) begin
            has_read = 1'b1; rd_acc = cyc; rd_idx = idx; rd_addr = a;
            if (idx < 0) begin
                rd_to = 1'b0; rd_lat = 0; rd_resp = cyc + 2; rd_data = ERR;
            end else begin
                rd_lat  = lat;
                rd_to   = (lat > T);
                rd_resp = cyc + (rd_to ? T : lat) + 1;
                rd_data = rd_to ? ERR : rdat;
            end
        end
        e_sre  = acc ? oh(idx) : '0;
        e_swe  = (rn && we) ? oh(idx) : '0;
        e_busy = has_read && rd_idx >= 0 && cyc > rd_acc && cyc < rd_resp;

        sv = NS'($urandom);
        for (int i = 0; i < NS; i++) sd[i*32 +: 32] = $urandom;
        if (e_busy) begin
            sv[rd_idx] = !rd_to && (cyc == rd_acc + rd_lat);
            if (sv[rd_idx]) sd[rd_idx*32 +: 32] = rd_data;
        end else begin
            sv = sv | extra_sv;
        end

        rst = rn; address = a; write_data = $urandom; write_mask = wm;
        write_enable = we; read_enable = re; fault_clear = fclr;
        s_read_valid = sv; s_read_data = sd;
        p_rst = rn; p_we = we; p_fclr = fclr; p_addr = a; p_acc = acc; p_idx = idx;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) drive_cycle(1'b1, 32'h0, 4'h0, 1'b0, 1'b0, 1'b0, 1, 32'h0);
    endtask

    // Per-cycle comparison of every output against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            chk("read_valid", {31'h0, read_valid}, {31'h0, e_rv});
            chk("read_data", read_data, m_rd);
            chk("busy", {31'h0, busy}, {31'h0, e_busy});
            chk("s_read_enable", {28'h0, s_read_enable}, {28'h0, e_sre});
            chk("s_write_enable", {28'h0, s_write_enable}, {28'h0, e_swe});
            chk("s_address", s_address, address);
            chk("s_write_data", s_write_data, write_data);
            chk("s_write_mask", {28'h0, s_write_mask}, {28'h0, write_mask});
            chk("fault_valid", {31'h0, fault_valid}, {31'h0, m_fv});
            chk("fault_addr", fault_addr, m_fa);
            chk("fault_is_write", {31'h0, fault_is_write}, {31'h0, m_fw});
            chk("fault_cause", {31'h0, fault_cause}, {31'h0, m_fc});
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog cyc=%0d", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] a;
        int          r, ri;
        rst = 1'b0; address = '0; write_data = '0; write_mask = '0;
        write_enable = 1'b0; read_enable = 1'b0; fault_clear = 1'b0;
        s_read_valid = '0; s_read_data = '0;

        drive_cycle(1'b0, 32'h0, 4'h0, 1'b0, 1'b0, 1'b0, 1, 32'h0);
        drive_cycle(1'b0, 32'h0, 4'h0, 1'b0, 1'b0, 1'b0, 1, 32'h0);
        idle(1);
        @(negedge clk);
        chk("pin_rst_rdata", read_data, 32'h0);
        chk("pin_rst_fault", {31'h0, fault_valid}, 32'h0);
        chk("pin_rst_busy", {31'h0, busy}, 32'h0);

        // write to slave 0
        drive_cycle(1'b1, 32'h90000010, 4'hF, 1'b1, 1'b0, 1'b0, 1, 32'h0);
        @(negedge clk); chk("pin_wr_en", {28'h0, s_write_enable}, 32'h1);

        // read slave 1, one-cycle slave latency
        drive_cycle(1'b1, 32'h10010005, 4'h0, 1'b0, 1'b1, 1'b0, 1, 32'h40);
        @(negedge clk); chk("pin_rd_strobe", {28'h0, s_read_enable}, 32'h2);
        idle(1);
        @(negedge clk); chk("pin_rd_busy", {31'h0, busy}, 32'h1);
        chk("pin_rd_novalid", {31'h0, read_valid}, 32'h0);
        idle(1);
        @(negedge clk); chk("pin_rd_valid", {31'h0, read_valid}, 32'h1);
        chk("pin_rd_data", read_data, 32'h00000040);
        idle(1);

        // unmapped read
        drive_cycle(1'b1, 32'h50000000, 4'h0, 1'b0, 1'b1, 1'b0, 1, 32'h0);
        @(negedge clk); chk("pin_um_nostrobe", {28'h0, s_read_enable}, 32'h0);
        idle(1);
        @(negedge clk); chk("pin_um_fv", {31'h0, fault_valid}, 32'h1);
        chk("pin_um_fa", fault_addr, 32'h50000000);
        idle(1);
        @(negedge clk); chk("pin_um_valid", {31'h0, read_valid}, 32'h1);
        chk("pin_um_data", read_data, 32'hDEADBEEF);
        chk("pin_um_cause", {31'h0, fault_cause}, 32'h0);
        drive_cycle(1'b1, 32'h0, 4'h0, 1'b0, 1'b0, 1'b1, 1, 32'h0);
        idle(1);
        @(negedge clk); chk("pin_clr1", {31'h0, fault_valid}, 32'h0);

        // timeout on slave 2
        drive_cycle(1'b1, 32'hA0000000, 4'h0, 1'b0, 1'b1, 1'b0, 99, 32'h0);
        idle(T);
        @(negedge clk); chk("pin_to_early", {31'h0, read_valid}, 32'h0);
        idle(1);
        @(negedge clk); chk("pin_to_valid", {31'h0, read_valid}, 32'h1);
        chk("pin_to_data", read_data, 32'hDEADBEEF);
        chk("pin_to_cause", {31'h0, fault_cause}, 32'h1);
        chk("pin_to_fa", fault_addr, 32'hA0000000);

        // boundary write just past slave 0: unmapped, must not overwrite the held fault
        drive_cycle(1'b1, 32'h90000800, 4'hF, 1'b1, 1'b0, 1'b0, 1, 32'h0);
        @(negedge clk); chk("pin_bnd_we", {28'h0, s_write_enable}, 32'h0);
        idle(1);
        @(negedge clk); chk("pin_keep_fa", fault_addr, 32'hA0000000);
        chk("pin_keep_w", {31'h0, fault_is_write}, 32'h0);
        drive_cycle(1'b1, 32'h0, 4'h0, 1'b0, 1'b0, 1'b1, 1, 32'h0);
        idle(1);
        @(negedge clk); chk("pin_clr2", {31'h0, fault_valid}, 32'h0);

        // last word of slave 0, request held during WAIT
        drive_cycle(1'b1, 32'h900007FC, 4'h0, 1'b0, 1'b1, 1'b0, 2, 32'h11112222);
        @(negedge clk); chk("pin_top_strobe", {28'h0, s_read_enable}, 32'h1);
        drive_cycle(1'b1, 32'h900007FC, 4'h0, 1'b0, 1'b1, 1'b0, 2, 32'h0);
        @(negedge clk); chk("pin_hold_nostrobe", {28'h0, s_read_enable}, 32'h0);
        drive_cycle(1'b1, 32'h900007FC, 4'h0, 1'b0, 1'b1, 1'b0, 2, 32'h0);
        drive_cycle(1'b1, 32'h0, 4'h0, 1'b0, 1'b0, 1'b0, 1, 32'h0);
        @(negedge clk); chk("pin_top_data", read_data, 32'h11112222);

        // reset while WAIT, late slave valid afterwards
        drive_cycle(1'b1, 32'h10010000, 4'h0, 1'b0, 1'b1, 1'b0, 99, 32'h0);
        idle(2);
        drive_cycle(1'b0, 32'h0, 4'h0, 1'b0, 1'b0, 1'b0, 1, 32'h0);
        extra_sv = 4'b0010;
        idle(1);
        @(negedge clk); chk("pin_mrst_rdata", read_data, 32'h0);
        chk("pin_mrst_busy", {31'h0, busy}, 32'h0);
        idle(2);
        extra_sv = '0;
        drive_cycle(1'b1, 32'h10010000, 4'h0, 1'b0, 1'b1, 1'b0, 1, 32'hCAFE0001);
        idle(2);
        @(negedge clk); chk("pin_after_rst", read_data, 32'hCAFE0001);

        // random phase
        for (int n = 0; n < 2000; n++) begin
            r  = $urandom_range(0, 9);
            ri = $urandom_range(0, NS - 1);
            if (r <= 5)      a = bs_a[ri] + ($urandom % sz_a[ri]);
            else if (r == 6) a = bs_a[ri] + sz_a[ri];
            else if (r == 7) a = bs_a[ri] - 32'h1;
            else             a = $urandom;
            drive_cycle($urandom_range(0, 199) != 0, a, 4'($urandom),
                        $urandom_range(0, 3) == 0, $urandom_range(0, 2) == 0,
                        $urandom_range(0, 15) == 0, $urandom_range(1, T + 4), $urandom);
        end
        idle(T + 4);
        @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
